frame_pixel_streamer: RTL

- Producer end of the raster RGB pixel interface that the corner/colour detectors consume.
- On a start pulse, scans one frame from the frame-buffer read port in raster order.
- Emits 8-bit r/g/b per pixel with x/y coordinates and start-of-frame/end-of-line markers, under valid/ready flow control.
- Sits between frame-buffer SRAM and the detection pipeline; lets detectors run on stored frames at clk rate, decoupled from VGA timing.

---
 rtl/frame_pixel_streamer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/frame_pixel_streamer.sv
// Raster pixel producer: scans one stored frame from the frame-buffer read port
// and streams {r,g,b,x,y,sof,eol} under valid/ready with credit-based read issue.
module frame_pixel_streamer #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rdata,
    output logic [7:0]        pix_r,
    output logic [7:0]        pix_g,
    output logic [7:0]        pix_b,
    output logic [9:0]        pix_x,
    output logic [9:0]        pix_y,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_valid,
    input  logic              pix_ready
);

    localparam int unsigned XY_W  = 10;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CR_W  = $clog2(FIFO_DEPTH + MEM_LAT + 2);

    typedef struct packed {
        logic [XY_W-1:0] x;
        logic [XY_W-1:0] y;
        logic            sof;
        logic            eol;
    } side_t;

    typedef struct packed {
        logic [23:0] rgb;
        side_t       sb;
    } entry_t;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [XY_W-1:0]   rd_x;
    logic [XY_W-1:0]   rd_y;
    side_t             iss_sb;
    logic              pipe_v  [MEM_LAT];
    side_t             pipe_sb [MEM_LAT];
    entry_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    entry_t            head_c;
    logic              pop_c;
    logic              push_c;
    logic              last_pop_c;
    logic              issue_c;
    logic [CR_W-1:0]   credit_c;

    assign head_c     = fifo_mem[rd_ptr];
    assign pix_valid  = (fifo_cnt != '0);
    assign pop_c      = pix_valid && pix_ready;
    assign push_c     = pipe_v[MEM_LAT-1];
    assign last_pop_c = pop_c && (head_c.sb.x == XY_W'(H_ACTIVE - 1))
                              && (head_c.sb.y == XY_W'(V_ACTIVE - 1));

    assign pix_r   = head_c.rgb[23:16];
    assign pix_g   = head_c.rgb[15:8];
    assign pix_b   = head_c.rgb[7:0];
    assign pix_x   = head_c.sb.x;
    assign pix_y   = head_c.sb.y;
    assign pix_sof = head_c.sb.sof;
    assign pix_eol = head_c.sb.eol;

    // Buffered plus in-flight entries after this edge; a pop this cycle frees a slot.
    always_comb begin
        credit_c = CR_W'(fifo_cnt) - CR_W'(pop_c) + CR_W'(mem_rd);
        for (int i = 0; i < int'(MEM_LAT); i++) begin
            credit_c = credit_c + CR_W'(pipe_v[i]);
        end
    end

    assign issue_c = (state == SCAN) && (credit_c < CR_W'(FIFO_DEPTH));

    // Scan FSM, read issue, sideband pipeline and output FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            addr_cnt <= '0;
            rd_x     <= '0;
            rd_y     <= '0;
            iss_sb   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < int'(MEM_LAT); i++) begin
                pipe_v[i]  <= 1'b0;
                pipe_sb[i] <= '0;
            end
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            done   <= 1'b0;
            mem_rd <= 1'b0;

            case (state)
                IDLE: begin
                    // The FIFO is empty in IDLE, so pixel (0,0) issues on start accept.
                    if (start) begin
                        state    <= SCAN;
                        busy     <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= '0;
                        iss_sb   <= '{x: '0, y: '0, sof: 1'b1, eol: 1'b0};
                        addr_cnt <= ADDR_W'(1);
                        rd_x     <= XY_W'(1);
                        rd_y     <= '0;
                    end
                end
                SCAN: begin
                    if (issue_c) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= addr_cnt;
                        iss_sb   <= '{x:   rd_x,
                                      y:   rd_y,
                                      sof: (rd_x == '0) && (rd_y == '0),
                                      eol: (rd_x == XY_W'(H_ACTIVE - 1))};
                        addr_cnt <= addr_cnt + ADDR_W'(1);
                        if (rd_x == XY_W'(H_ACTIVE - 1)) begin
                            rd_x <= '0;
                            if (rd_y == XY_W'(V_ACTIVE - 1)) begin
                                state <= DRAIN;
                            end else begin
                                rd_y <= rd_y + XY_W'(1);
                            end
                        end else begin
                            rd_x <= rd_x + XY_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (last_pop_c) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            pipe_v[0]  <= mem_rd;
            pipe_sb[0] <= iss_sb;
            for (int i = 1; i < int'(MEM_LAT); i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_sb[i] <= pipe_sb[i-1];
            end

            if (push_c) begin
                fifo_mem[wr_ptr] <= '{rgb: mem_rdata, sb: pipe_sb[MEM_LAT-1]};
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule
